// File: rtl/led_blink_driver.sv
// Turns a one-cycle start request into blink_num LED pulses timed by an internal
// tick prescaler, with a busy level and a one-cycle done pulse on completion.
module led_blink_driver #(
  parameter int unsigned TICK_DIV   = 10000,
  parameter int unsigned ON_TICKS   = 50,
  parameter int unsigned OFF_TICKS  = 50,
  parameter int unsigned CNT_W      = 4,
  parameter logic        LED_ACTIVE = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [CNT_W-1:0] blink_num,
  output logic             led_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PH_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               led_q, led_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tick_c;

  // With TICK_DIV == 1 the prescaler stays at 0 and every cycle is a tick.
  assign tick_c = (pre_q == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      phase_q <= '0;
      rem_q   <= '0;
      led_q   <= ~LED_ACTIVE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        pre_d   = '0;
        phase_d = '0;
        if (start && (blink_num != '0)) begin
          state_d = ON;
          rem_d   = blink_num;
        end
      end
      ON: begin
        pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
        if (tick_c) begin
          if (phase_q == PH_W'(ON_TICKS - 1)) begin
            state_d = OFF;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
      OFF: begin
        pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
        if (tick_c) begin
          if (phase_q == PH_W'(OFF_TICKS - 1)) begin
            phase_d = '0;
            // Last OFF phase finishes the pattern; otherwise start the next pulse.
            if (rem_q > CNT_W'(1)) begin
              rem_d   = rem_q - CNT_W'(1);
              state_d = ON;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    led_d  = (state_d == ON) ? LED_ACTIVE : ~LED_ACTIVE;
    busy_d = (state_d != IDLE);
  end

  assign led_out = led_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_led_blink_driver.sv
// Directed bench for led_blink_driver at TICK_DIV=4, ON=2, OFF=3 ticks:
// pulses are 8 cycles lit, 12 dark; an inverted-polarity instance runs alongside.
module tb_led_blink_driver;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       start;
  logic [3:0] blink_num;
  logic       led, busy, done;
  logic       led_n, busy_n, done_n;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  led_blink_driver #(
    .TICK_DIV(4), .ON_TICKS(2), .OFF_TICKS(3), .CNT_W(4), .LED_ACTIVE(1'b1)
  ) u_dut (
    .sys_clk(clk), .sys_rst(sys_rst), .start(start), .blink_num(blink_num),
    .led_out(led), .busy(busy), .done(done)
  );

  led_blink_driver #(
    .TICK_DIV(4), .ON_TICKS(2), .OFF_TICKS(3), .CNT_W(4), .LED_ACTIVE(1'b0)
  ) u_dut_n (
    .sys_clk(clk), .sys_rst(sys_rst), .start(start), .blink_num(blink_num),
    .led_out(led_n), .busy(busy_n), .done(done_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check both instances against one expected lit/busy/done triple.
  task automatic check_out(input string tag, input bit lit, input bit b, input bit d);
    check({tag, ".led"},    32'(led),    32'(lit));
    check({tag, ".led_n"},  32'(led_n),  32'(!lit));
    check({tag, ".busy"},   32'(busy),   32'(b));
    check({tag, ".busy_n"}, 32'(busy_n), 32'(b));
    check({tag, ".done"},   32'(done),   32'(d));
    check({tag, ".done_n"}, 32'(done_n), 32'(d));
  endtask

  task automatic start_pat(input int n);
    start     = 1'b1;
    blink_num = 4'(n);
    step();
    start     = 1'b0;
  endtask

  // Called just after the accept edge; ends just after the done edge.
  task automatic run_pattern(input string tag, input int n, input bit hold,
                             input int inj_at, input bit inj_start, input int inj_num);
    for (int c = 0; c < n * 20; c++) begin
      check_out(tag, (c % 20) < 8, 1'b1, 1'b0);
      start = hold;
      if (c == inj_at) begin
        blink_num = 4'(inj_num);
        if (inj_start) start = 1'b1;
      end
      step();
    end
    check_out({tag, ".end"}, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    sys_rst   = 1'b1;
    start     = 1'b0;
    blink_num = 4'd0;
    step();
    check_out("reset", 1'b0, 1'b0, 1'b0);
    sys_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check_out("idle", 1'b0, 1'b0, 1'b0);
    end

    start_pat(3);
    run_pattern("basic3", 3, 1'b0, -1, 1'b0, 0);
    step();
    check_out("basic3.after", 1'b0, 1'b0, 1'b0);

    start_pat(0);
    for (int i = 0; i < 5; i++) begin
      check_out("zero_req", 1'b0, 1'b0, 1'b0);
      step();
    end

    start_pat(3);
    run_pattern("busy_req", 3, 1'b0, 30, 1'b1, 5);
    step();
    check_out("busy_req.after", 1'b0, 1'b0, 1'b0);

    start_pat(2);
    run_pattern("num_change", 2, 1'b0, 10, 1'b0, 9);
    step();
    check_out("num_change.after", 1'b0, 1'b0, 1'b0);

    start     = 1'b1;
    blink_num = 4'd1;
    step();
    for (int p = 0; p < 3; p++) begin
      run_pattern("b2b", 1, 1'b1, -1, 1'b0, 0);
      if (p == 2) start = 1'b0;
      step();
    end
    check_out("b2b.after", 1'b0, 1'b0, 1'b0);

    start_pat(2);
    for (int c = 0; c < 25; c++) begin
      check_out("pre_rst", (c % 20) < 8, 1'b1, 1'b0);
      step();
    end
    sys_rst = 1'b1;
    step();
    check_out("mid_rst", 1'b0, 1'b0, 1'b0);
    sys_rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      check_out("post_rst", 1'b0, 1'b0, 1'b0);
    end
    start_pat(1);
    run_pattern("fresh1", 1, 1'b0, -1, 1'b0, 0);
    step();

    start_pat(15);
    run_pattern("max15", 15, 1'b0, -1, 1'b0, 0);
    step();
    check_out("max15.after", 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_blink_driver.md
# led_blink_driver

Output-side companion to the key debouncer: converts a one-cycle request (typically a debounced key edge or an I2C transaction status event) into a visible LED blink pattern of N pulses. Timing derives from an internal tick prescaler with the same default period as the key debounce sample tick (10000 clocks). A busy/done handshake lets the control logic sequence requests. All outputs are registered.

## Interface
- TICK_DIV, 10000: sys_clk cycles per tick; must be at least 1.
- ON_TICKS, 50: ticks the LED is lit per pulse; must be at least 1.
- OFF_TICKS, 50: ticks the LED is dark after each pulse, including the last one; must be at least 1.
- CNT_W, 4: width of blink_num.
- LED_ACTIVE, 1'b1: led_out level meaning "lit".
- sys_clk  in  1  single clock; all logic on rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- start  in  1  request pulse; sampled every cycle.
- blink_num  in  CNT_W  number of pulses; captured when start is accepted.
- led_out  out  1  LED drive.
- busy  out  1  high while a pattern is in progress.
- done  out  1  one-cycle pulse when a pattern completes.

## Operation
- States:
  - IDLE: led_out = !LED_ACTIVE, busy = 0.
  - ON: led_out = LED_ACTIVE, busy = 1.
  - OFF: led_out = !LED_ACTIVE, busy = 1.
- Internal counters:
  - Prescaler, width $clog2(TICK_DIV), range 0..TICK_DIV-1. A tick occurs when it equals TICK_DIV-1; it then wraps to 0.
  - Phase counter counts ticks within ON or OFF.
  - Remaining counter, CNT_W bits.
- Accept rule: in IDLE with start=1 and blink_num != 0, the pattern starts.
  - State goes to ON.
  - Prescaler and phase counter clear to 0.
  - Remaining counter loads blink_num.
- Ignored requests:
  - start in ON or OFF is ignored; there is no queueing.
  - start with blink_num = 0 is ignored; busy and done stay low.
- ON to OFF: on the tick that completes ON_TICKS ticks. Phase counter clears.
- End of OFF, on the tick that completes OFF_TICKS ticks:
  - If remaining > 1: decrement remaining, go to ON, clear phase counter.
  - Otherwise: go to IDLE and set done = 1 for exactly one cycle.
- blink_num changes after acceptance have no effect.
- Maximum pattern: 2^CNT_W - 1 pulses. blink_num is not reduced modulo anything.

## Timing
- Reset values, applied at the first rising edge with sys_rst=1:
  - State IDLE.
  - led_out = !LED_ACTIVE, busy = 0, done = 0.
  - All counters 0.
- Reset mid-pattern aborts immediately. No done pulse is generated.
- Start latency: start sampled at edge k gives led_out lit and busy = 1 from edge k.
- Each ON phase lasts exactly ON_TICKS × TICK_DIV cycles. Each OFF phase lasts exactly OFF_TICKS × TICK_DIV cycles.
- busy stays high for exactly N × (ON_TICKS + OFF_TICKS) × TICK_DIV cycles, where N is the captured blink_num.
- In the edge where busy falls, done rises. done is high for exactly 1 cycle.
- start asserted in the same cycle done is high is accepted, because the state is already IDLE. busy then reasserts at the next edge, so the gap is 1 cycle.
- TICK_DIV = 1: a tick occurs every cycle, and the prescaler is a constant 0.

## Test plan
Test parameters: TICK_DIV=4, ON_TICKS=2, OFF_TICKS=3, CNT_W=4, LED_ACTIVE=1.
1. Reset, then idle 20 cycles -> led_out=0, busy=0, done=0 throughout.
2. Basic pattern: start=1 with blink_num=3 for one cycle -> led_out is high for 8 cycles then low for 12, repeated 3 times. busy is high for 60 cycles. done pulses once, in the cycle after the last OFF cycle.
3. Zero and busy requests:
   - blink_num=0 with start -> no busy, no done, led_out stays 0.
   - start with blink_num=5 during a running pattern -> ignored; the original 3 pulses complete unchanged.
4. Back-to-back:
   - Hold start=1 with blink_num=1 continuously -> patterns of 20 busy cycles, each separated by exactly one idle cycle with done=1.
   - Changing blink_num mid-pattern has no effect.
5. Reset mid-pattern: sys_rst=1 during the second ON phase -> after that edge led_out=0, busy=0, done=0, and no done follows.
   - A fresh start with blink_num=1 afterwards gives a full-length 8-cycle ON phase, confirming the prescaler was cleared.
6. Maximum count and polarity: blink_num=15 -> exactly 15 pulses, 300 busy cycles.
   - Repeat with LED_ACTIVE=0 -> led_out is inverted: idle level 1, lit level 0.
